// File: rtl/idu.sv
// Two-entry instruction buffer with RV32I field/immediate decode of the head entry.
// Optional perf counters: define IDU_PERF_CNT_EN to add perf_inst_cnt / perf_stall_cnt.
module idu #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [2:0]  out_type
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

    state_e      state_q, state_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] pc_q   [2];
    logic [31:0] inst_q [2];
    logic        push, pop;
    logic [31:0] head_inst;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (pop && !push) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push && !flush) begin
                pc_q[wr_ptr_q]   <= in_pc;
                inst_q[wr_ptr_q] <= in_inst;
            end
        end
    end

    // Empty buffer presents a NOP so downstream decode stays well-defined.
    assign head_inst = (state_q == ST_EMPTY) ? NOP_INST : inst_q[rd_ptr_q];
    assign out_pc    = (state_q == ST_EMPTY) ? '0 : pc_q[rd_ptr_q];
    assign out_inst  = head_inst;
    assign out_rs1   = head_inst[19:15];
    assign out_rs2   = head_inst[24:20];
    assign out_rd    = head_inst[11:7];

    always_comb begin
        out_type = 3'd7;
        out_imm  = '0;
        unique case (head_inst[6:0])
            7'b0110011: out_type = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                out_type = 3'd1;
                out_imm  = {{20{head_inst[31]}}, head_inst[31:20]};
            end
            7'b0100011: begin
                out_type = 3'd2;
                out_imm  = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            end
            7'b1100011: begin
                out_type = 3'd3;
                out_imm  = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                            head_inst[30:25], head_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                out_type = 3'd4;
                out_imm  = {head_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                out_type = 3'd5;
                out_imm  = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                            head_inst[20], head_inst[30:21], 1'b0};
            end
            default: begin
                out_type = 3'd7;
                out_imm  = '0;
            end
        endcase
    end

`ifdef IDU_PERF_CNT_EN
    logic [31:0] perf_inst_q, perf_stall_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop && !flush)          perf_inst_q  <= perf_inst_q + 32'd1;
            if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_inst_cnt  = perf_inst_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_idu.sv
// Scoreboard bench for idu: accepted entries are queued with table-derived decode
// expectations and compared against the head every cycle it is valid.
module tb_idu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_type;
`ifdef IDU_PERF_CNT_EN
    logic [31:0] perf_inst_cnt, perf_stall_cnt;
`endif

    idu #(.NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_type(out_type)
`ifdef IDU_PERF_CNT_EN
        , .perf_inst_cnt(perf_inst_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam int NTAB = 14;
    logic [31:0] tab_inst [NTAB] = '{
        32'h00500093, 32'hFE000EE3, 32'h0000006F, 32'h00000000, 32'h123450B7,
        32'h00112623, 32'h002081B3, 32'hFFF00093, 32'hFFDFF06F, 32'hFF80A183,
        32'h00208463, 32'h000080E7, 32'h00001517, 32'h00000073};
    logic [2:0]  tab_typ  [NTAB] = '{
        3'd1, 3'd3, 3'd5, 3'd7, 3'd4, 3'd2, 3'd0, 3'd1, 3'd5, 3'd1, 3'd3, 3'd1, 3'd4, 3'd1};
    logic [31:0] tab_imm  [NTAB] = '{
        32'h00000005, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h12345000,
        32'h0000000C, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
        32'h00000008, 32'h00000000, 32'h00001000, 32'h00000000};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  typ;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cur_idx = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_inst_cnt = '0;
    logic [31:0] m_stall_cnt = '0;
    bit          can_push;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Monitor: compare current outputs to the model, then advance the model for the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_inst_cnt  = '0;
            m_stall_cnt = '0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("in_ready", 32'(in_ready), 32'(sb.size() != 2));
            if (sb.size() != 0) begin
                e = sb[0];
                check("head_pc", out_pc, e.pc);
                check("head_inst", out_inst, e.inst);
                check("head_type", 32'(out_type), 32'(e.typ));
                check("head_imm", out_imm, e.imm);
                check("head_rd", 32'(out_rd), 32'(e.inst[11:7]));
                check("head_rs1", 32'(out_rs1), 32'(e.inst[19:15]));
                check("head_rs2", 32'(out_rs2), 32'(e.inst[24:20]));
            end else begin
                check("empty_pc", out_pc, 32'h0);
                check("empty_inst", out_inst, 32'h00000013);
                check("empty_type", 32'(out_type), 32'd1);
                check("empty_imm", out_imm, 32'h0);
                check("empty_rd", 32'(out_rd), 32'd0);
            end
`ifdef IDU_PERF_CNT_EN
            check("perf_inst", perf_inst_cnt, m_inst_cnt);
            check("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif
            if (sb.size() != 0 && !out_ready) m_stall_cnt = m_stall_cnt + 32'd1;
            can_push = (sb.size() != 2);
            if (flush) begin
                sb.delete();
            end else begin
                if (sb.size() != 0 && out_ready) begin
                    void'(sb.pop_front());
                    m_inst_cnt = m_inst_cnt + 32'd1;
                end
                if (in_valid && can_push)
                    sb.push_back('{pc: in_pc, inst: tab_inst[cur_idx],
                                   imm: tab_imm[cur_idx], typ: tab_typ[cur_idx]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input int idx);
        in_pc   = pc;
        cur_idx = idx;
        in_inst = tab_inst[idx];
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] pc, input int idx);
        drive(pc, idx);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        rst = 1'b1;
        step();

        // Single addi with consumer ready: one-cycle latency
        out_ready = 1'b1;
        drive(32'h80000000, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_type", 32'(out_type), 32'd1);
        check("lat_rd", 32'(out_rd), 32'd1);
        check("lat_imm", out_imm, 32'd5);
        repeat (2) step();

        // Fill to FULL, third offer held, then drain in order
        out_ready = 1'b0;
        send(32'h80000000, 0);
        send(32'h80000004, 1);
        drive(32'h80000008, 2);
        in_valid = 1'b1;
        repeat (3) step();
        check("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (4) step();

        // Flush while FULL with a simultaneous offer
        out_ready = 1'b0;
        send(32'h90000000, 4);
        send(32'h90000004, 5);
        drive(32'h90000008, 6);
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_inst", out_inst, 32'h00000013);
        step();

        // Every decode table entry
        out_ready = 1'b1;
        for (int i = 0; i < NTAB; i++) send(32'h00001000 + 32'(4 * i), i);
        repeat (3) step();

        // Streaming push+pop in ONE state
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(32'h00002000 + 32'(4 * i), i % NTAB);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 2) != 0;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            drive($urandom, int'($urandom_range(0, NTAB - 1)));
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset mid-operation discards entries
        out_ready = 1'b0;
        send(32'hA0000000, 7);
        send(32'hA0000004, 8);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pc", out_pc, 32'h0);

        // 3 pops and 4 stall cycles from a fresh reset
        out_ready = 1'b0;
        drive(32'hB0000000, 9);
        in_valid = 1'b1;
        step();
        drive(32'hB0000004, 10);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        drive(32'hB0000008, 11);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
`ifdef IDU_PERF_CNT_EN
        check("perf_inst_3", perf_inst_cnt, 32'd3);
        check("perf_stall_4", perf_stall_cnt, 32'd4);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("perf_inst_rst", perf_inst_cnt, 32'd0);
        check("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
